// File: rtl/xor_tree_seq_ctrl_if.sv
// Valid/ready bundle between the operand producer, the XOR group sequencer and
// the result consumer. The sequencer takes the slave side and the environment takes the master side.
interface xor_tree_seq_ctrl_if #(
  parameter int WIDTH = 35
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vector;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_xor
  );

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_xor
  );

endinterface

// File: rtl/xor_tree_seq_ctrl.sv
// Folds a serial stream of WIDTH-bit operands into groups of NUM_VEC and presents the XOR of each group.
// Defining XOR_SEQ_PARITY_EN adds the out_parity port, which is the reduction XOR of out_xor.
module xor_tree_seq_ctrl #(
  parameter int NUM_VEC = 3,
  parameter int WIDTH   = 35
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  xor_tree_seq_ctrl_if.slave bus,
  output logic               busy
`ifdef XOR_SEQ_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  localparam int CNT_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             in_xfer;

  // Every handshake output is decoded from the state alone. This keeps in_valid and out_ready off any combinational path to the outputs.
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_xor   = acc;
  assign busy          = (state != IDLE);
  assign in_xfer       = bus.in_valid && (state != DONE);

`ifdef XOR_SEQ_PARITY_EN
  assign out_parity = ^acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = bus.in_vector;
          cnt_d   = CNT_W'(1);
          state_d = (NUM_VEC == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = acc ^ bus.in_vector;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Abort wins over any same-cycle transfer. A vector accepted in this cycle is dropped, and a result delivered in this cycle still counts as delivered.
    if (abort) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_xor_tree_seq_ctrl.sv
// Randomized and directed checks of xor_tree_seq_ctrl. One instance uses NUM_VEC=3 and WIDTH=35; the other uses NUM_VEC=1 and WIDTH=16.
// Each instance is compared against a group-level model: a count of accepted vectors, their XOR, and a flag for a pending result.
module tb_xor_tree_seq_ctrl;

  logic clk;
  logic rst_n;
  logic abort;
  logic busy0, busy1;
`ifdef XOR_SEQ_PARITY_EN
  logic par0, par1;
`endif

  xor_tree_seq_ctrl_if #(.WIDTH(35)) bus0 ();
  xor_tree_seq_ctrl_if #(.WIDTH(16)) bus1 ();

  xor_tree_seq_ctrl #(.NUM_VEC(3), .WIDTH(35)) dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus0), .busy(busy0)
`ifdef XOR_SEQ_PARITY_EN
    , .out_parity(par0)
`endif
  );

  xor_tree_seq_ctrl #(.NUM_VEC(1), .WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus1), .busy(busy1)
`ifdef XOR_SEQ_PARITY_EN
    , .out_parity(par1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  bit          checks_on = 0;
  bit          pend [2];
  int          naccepted [2];
  logic [34:0] gxor [2];
  int          nvec [2] = '{3, 1};

  task automatic checkOutput(input string tag, input logic [34:0] actual, input logic [34:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("in_ready", 35'(bus0.in_ready), 35'(!pend[0]));
    checkOutput("out_valid", 35'(bus0.out_valid), 35'(pend[0]));
    checkOutput("out_xor", bus0.out_xor, gxor[0]);
    checkOutput("busy", 35'(busy0), 35'(pend[0] || naccepted[0] > 0));
    checkOutput("s_in_ready", 35'(bus1.in_ready), 35'(!pend[1]));
    checkOutput("s_out_valid", 35'(bus1.out_valid), 35'(pend[1]));
    checkOutput("s_out_xor", 35'(bus1.out_xor), gxor[1]);
    checkOutput("s_busy", 35'(busy1), 35'(pend[1] || naccepted[1] > 0));
`ifdef XOR_SEQ_PARITY_EN
    checkOutput("parity", 35'(par0), 35'(^gxor[0]));
    checkOutput("s_parity", 35'(par1), 35'(^gxor[1]));
`endif
  endtask

  // Group-level model. It is evaluated once per clock edge, using the inputs that were driven for that edge.
  task automatic modelUpdate();
    bit          v [2];
    bit          ordy [2];
    logic [34:0] vec [2];
    v[0] = bus0.in_valid;  ordy[0] = bus0.out_ready;  vec[0] = bus0.in_vector;
    v[1] = bus1.in_valid;  ordy[1] = bus1.out_ready;  vec[1] = 35'(bus1.in_vector);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort || (pend[i] && ordy[i])) begin
        pend[i] = 0;  naccepted[i] = 0;  gxor[i] = '0;
      end else if (!pend[i] && v[i]) begin
        gxor[i] ^= vec[i];
        naccepted[i]++;
        if (naccepted[i] == nvec[i]) pend[i] = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ab, input bit v, input logic [34:0] vec,
                               input bit ordy, input bit sv = 0, input logic [15:0] svec = 16'h0,
                               input bit sordy = 1);
    if (checks_on) compareAll();
    rst_n          = rst;
    abort          = ab;
    bus0.in_valid  = v;
    bus0.in_vector = vec;
    bus0.out_ready = ordy;
    bus1.in_valid  = sv;
    bus1.in_vector = svec;
    bus1.out_ready = sordy;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  function automatic logic [34:0] rnd35();
    return 35'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [34:0] va, vb, vc;
    va = 35'd7041284509;
    vb = 35'd14066143831;
    vc = 35'd9548617438;
    rst_n = 0; abort = 0;
    bus0.in_valid = 0; bus0.in_vector = '0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_vector = '0; bus1.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; naccepted[i] = 0; gxor[i] = '0;
    end
    @(negedge clk);

    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0);
    checks_on = 1;
    checkOutput("rst_in_ready", 35'(bus0.in_ready), 35'd1);
    checkOutput("rst_out_valid", 35'(bus0.out_valid), 35'd0);
    checkOutput("rst_out_xor", bus0.out_xor, 35'd0);
    checkOutput("rst_busy", 35'(busy0), 35'd0);

    // Basic group
    applyStimulus(1, 0, 1, va, 1);
    applyStimulus(1, 0, 1, vb, 1);
    applyStimulus(1, 0, 1, vc, 1);
    checkOutput("basic_xor", bus0.out_xor, 35'd3707600148);
    checkOutput("basic_valid", 35'(bus0.out_valid), 35'd1);
    applyStimulus(1, 0, 0, '0, 1);
    checkOutput("basic_ready_back", 35'(bus0.in_ready), 35'd1);

    // Backpressure
    applyStimulus(1, 0, 1, va, 0);
    applyStimulus(1, 0, 1, vb, 0);
    applyStimulus(1, 0, 1, vc, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_xor", bus0.out_xor, 35'd3707600148);
      applyStimulus(1, 0, 1, 35'h123, 0);
    end
    checkOutput("bp_xor_held", bus0.out_xor, 35'd3707600148);
    applyStimulus(1, 0, 0, '0, 1);
    checkOutput("bp_idle", 35'(busy0), 35'd0);

    // Gapped input
    applyStimulus(1, 0, 1, 35'd1, 0);
    applyStimulus(1, 0, 0, rnd35(), 0);
    applyStimulus(1, 0, 0, rnd35(), 0);
    applyStimulus(1, 0, 1, 35'd2, 0);
    applyStimulus(1, 0, 0, rnd35(), 0);
    applyStimulus(1, 0, 1, 35'd4, 0);
    checkOutput("gap_xor", bus0.out_xor, 35'd7);
    checkOutput("gap_busy", 35'(busy0), 35'd1);
    applyStimulus(1, 0, 0, '0, 1);

    // Abort mid-group
    applyStimulus(1, 0, 1, 35'd5, 1);
    applyStimulus(1, 0, 1, 35'd9, 1);
    applyStimulus(1, 1, 1, 35'd3, 1);
    checkOutput("abort_xor", bus0.out_xor, 35'd0);
    checkOutput("abort_busy", 35'(busy0), 35'd0);
    applyStimulus(1, 0, 1, 35'd1, 0);
    applyStimulus(1, 0, 1, 35'd2, 0);
    applyStimulus(1, 0, 1, 35'd3, 0);
    checkOutput("after_abort_xor", bus0.out_xor, 35'd0);
    checkOutput("after_abort_valid", 35'(bus0.out_valid), 35'd1);

    // Reset while a result is pending
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("rst_done_valid", 35'(bus0.out_valid), 35'd0);
    checkOutput("rst_done_xor", bus0.out_xor, 35'd0);
    checkOutput("rst_done_ready", 35'(bus0.in_ready), 35'd1);

    // Single-vector groups
    applyStimulus(1, 0, 0, '0, 1, 1, 16'h5A5A, 0);
    checkOutput("s_one_xor", 35'(bus1.out_xor), 35'h5A5A);
    checkOutput("s_one_ready", 35'(bus1.in_ready), 35'd0);
    applyStimulus(1, 0, 0, '0, 1, 1, 16'h1111, 0);
    checkOutput("s_one_held", 35'(bus1.out_xor), 35'h5A5A);
    applyStimulus(1, 0, 0, '0, 1, 0, 16'h0, 1);
    checkOutput("s_one_ready_back", 35'(bus1.in_ready), 35'd1);

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) != 0, $urandom_range(39) == 0,
                    $urandom_range(9) < 7, rnd35(), $urandom_range(9) < 6,
                    $urandom_range(9) < 7, 16'($urandom()), $urandom_range(9) < 6);
    end
    compareAll();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
